// File: rtl/ntt_pkg.sv
// ============================================================================
// Module   : ntt_pkg
// Brief    : Shared constants, zeta ROM, FSM state type and modular
//            arithmetic helpers for the Kyber-domain NTT/INTT engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int Q         = 3329;
    localparam int N         = 256;
    localparam logic [11:0] N_INV = 12'd3303;
    localparam int BARRETT_V = 20159;

    localparam logic [12:0] Q_W13 = 13'd3329;
    localparam logic [25:0] Q_W26 = 26'd3329;
    localparam logic [39:0] BARRETT_V_W40 = 40'd20159;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // zeta[k] = 17^bitrev7(k) mod Q
    localparam int ZETA_ROM [128] = '{
        1,    1729, 2580, 3289, 2642, 630,  1897, 848,
        1062, 1919, 193,  797,  2786, 3260, 569,  1746,
        296,  2447, 1339, 1476, 3046, 56,   2240, 1333,
        1426, 2094, 535,  2882, 2393, 2879, 1974, 821,
        289,  331,  3253, 1756, 1197, 2304, 2277, 2055,
        650,  1977, 2513, 632,  2865, 33,   1320, 1915,
        2319, 1435, 807,  452,  1438, 2868, 1534, 2402,
        2647, 2617, 1481, 648,  2474, 3110, 1227, 910,
        17,   2761, 583,  2649, 1637, 723,  2288, 1100,
        1409, 2662, 3281, 233,  756,  2156, 3015, 3050,
        1703, 1651, 2789, 1789, 1847, 952,  1461, 2687,
        939,  2308, 2437, 2388, 733,  2337, 268,  641,
        1584, 2298, 2037, 3220, 375,  2549, 2090, 1645,
        1063, 319,  2773, 757,  2099, 561,  2466, 2594,
        2804, 1092, 403,  1026, 1143, 2150, 2775, 886,
        1722, 1212, 1874, 1029, 2110, 2935, 885,  2154
    };

    function automatic logic [11:0] load_reduce(input logic [11:0] x);
        logic [12:0] v;
        v = {1'b0, x};
        if (v >= Q_W13) v = v - Q_W13;
        return 12'(v);
    endfunction

    function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_W13) s = s - Q_W13;
        return 12'(s);
    endfunction

    function automatic logic [11:0] mod_sub(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[12]) d = d + Q_W13;
        return 12'(d);
    endfunction

    // V is rounded up, so the quotient estimate can exceed the true one by 1;
    // the remainder then goes negative and gets one +Q correction.
    function automatic logic [11:0] barrett_mul(input logic [11:0] a, input logic [11:0] b);
        logic [23:0] p;
        logic [39:0] pv;
        logic [13:0] qe;
        logic [25:0] qq;
        logic [25:0] r;
        p  = {12'd0, a} * {12'd0, b};
        pv = {16'd0, p} * BARRETT_V_W40;
        qe = 14'(pv >> 26);
        qq = {12'd0, qe} * Q_W26;
        r  = {2'b00, p} - qq;
        if (r[25]) r = r + Q_W26;
        return 12'(r);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_intt_butterfly.sv
// ============================================================================
// Module   : ntt_butterfly
// Brief    : Combinational CT/GS butterfly with a dual-multiply scale mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_butterfly
    import ntt_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_zeta,
    input  logic         i_inv,
    input  logic         i_scale,
    output logic [W-1:0] o_a,
    output logic [W-1:0] o_b
);

    logic [W-1:0] w_diff;
    logic [W-1:0] w_mul_in;
    logic [W-1:0] w_prod_b;
    logic [W-1:0] w_prod_a;

    assign w_diff   = mod_sub(i_b, i_a);
    assign w_mul_in = (i_inv && !i_scale) ? w_diff : i_b;
    assign w_prod_b = barrett_mul(i_zeta, w_mul_in);
    // Second multiplier only matters in scale mode, where both words are scaled.
    assign w_prod_a = barrett_mul(i_zeta, i_a);

    always_comb begin
        o_a = mod_add(i_a, w_prod_b);
        o_b = mod_sub(i_a, w_prod_b);
        if (i_scale) begin
            o_a = w_prod_a;
            o_b = w_prod_b;
        end else if (i_inv) begin
            o_a = mod_add(i_a, i_b);
            o_b = w_prod_b;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ntt_intt_core.sv
// ============================================================================
// Module   : ntt_intt_core
// Brief    : 7-layer Kyber NTT / INTT engine, NUM_BF butterflies per cycle,
//            parallel coefficient load/unload with start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_intt_core
    import ntt_pkg::*;
#(
    parameter int NUM_BF = 1,
    parameter int W      = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                inv_i,
    input  logic [N-1:0][W-1:0] coeff_i,
    output logic [N-1:0][W-1:0] coeff_o,
    output logic                busy_o,
    output logic                done_o
);

    if (!(NUM_BF == 1 || NUM_BF == 2 || NUM_BF == 4 || NUM_BF == 8)) begin : g_bad_num_bf
        $error("ntt_intt_core: NUM_BF must be 1, 2, 4 or 8");
    end
    if (((1 << W) >= 2 * Q) || ((1 << W) < Q)) begin : g_bad_w
        $error("ntt_intt_core: W must hold [0, Q-1] and satisfy 2^W < 2*Q");
    end

    localparam logic [6:0] c_step = 7'(NUM_BF);
    localparam logic [6:0] c_last = 7'(128 - NUM_BF);

    state_t             r_state;
    logic               r_inv;
    logic               r_busy;
    logic               r_done;
    logic [2:0]         r_layer;
    logic [6:0]         r_b;
    logic [N-1:0][W-1:0] r_coef;

    logic               w_scale;
    logic [2:0]         w_sh;
    logic [7:0]         w_ia   [NUM_BF];
    logic [7:0]         w_ib   [NUM_BF];
    logic [W-1:0]       w_zeta [NUM_BF];
    logic [W-1:0]       w_oa   [NUM_BF];
    logic [W-1:0]       w_ob   [NUM_BF];

    assign w_scale = (r_state == SCALE);
    // log2 of the butterfly span: forward shrinks 128..2, inverse grows 2..128
    assign w_sh    = r_inv ? (r_layer + 3'd1) : (3'd7 - r_layer);

    for (genvar k = 0; k < NUM_BF; k++) begin : g_lane
        logic [6:0] w_bidx;
        logic [6:0] w_grp;
        logic [6:0] w_off;
        logic [7:0] w_len;
        logic [7:0] w_j;
        logic [6:0] w_zidx;

        assign w_bidx = r_b + 7'(k);
        assign w_len  = 8'd1 << w_sh;
        assign w_grp  = w_bidx >> w_sh;
        assign w_off  = w_bidx & 7'(w_len - 8'd1);
        assign w_j    = ({1'b0, w_grp} << ({1'b0, w_sh} + 4'd1)) | {1'b0, w_off};
        assign w_zidx = r_inv ? 7'((8'd1 << (3'd7 - r_layer)) - 8'd1 - {1'b0, w_grp})
                              : 7'((8'd1 << r_layer) + {1'b0, w_grp});

        assign w_ia[k]   = w_scale ? {w_bidx, 1'b0} : w_j;
        assign w_ib[k]   = w_scale ? {w_bidx, 1'b1} : (w_j + w_len);
        assign w_zeta[k] = w_scale ? N_INV : W'(ZETA_ROM[w_zidx]);

        ntt_butterfly #(
            .W (W)
        ) u_bf (
            .i_a     (r_coef[w_ia[k]]),
            .i_b     (r_coef[w_ib[k]]),
            .i_zeta  (w_zeta[k]),
            .i_inv   (r_inv),
            .i_scale (w_scale),
            .o_a     (w_oa[k]),
            .o_b     (w_ob[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_inv   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_layer <= 3'd0;
            r_b     <= 7'd0;
            r_coef  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The cycle showing done_o also ignores start.
                    if (start_i && !r_done) begin
                        for (int i = 0; i < N; i++) begin
                            r_coef[i] <= load_reduce(coeff_i[i]);
                        end
                        r_inv   <= inv_i;
                        r_layer <= 3'd0;
                        r_b     <= 7'd0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < NUM_BF; k++) begin
                        r_coef[w_ia[k]] <= w_oa[k];
                        r_coef[w_ib[k]] <= w_ob[k];
                    end
                    r_b <= r_b + c_step;
                    if (r_b == c_last) begin
                        if (r_layer == 3'd6) begin
                            r_layer <= 3'd0;
                            r_state <= r_inv ? SCALE : DONE;
                        end else begin
                            r_layer <= r_layer + 3'd1;
                        end
                    end
                end
                SCALE: begin
                    for (int k = 0; k < NUM_BF; k++) begin
                        r_coef[w_ia[k]] <= w_oa[k];
                        r_coef[w_ib[k]] <= w_ob[k];
                    end
                    r_b <= r_b + c_step;
                    if (r_b == c_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign coeff_o = r_coef;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

`default_nettype wire
